// File: rtl/mem_responder.sv
// Word-array memory model answering read/write enable handshakes after a fixed latency.
// Optional build macro MEM_RESP_STATS_EN adds read/write statistics counters.
module mem_responder #(
   parameter logic [63:0] BASE     = 64'd0,
   parameter int          DEPTH    = 8192,
   parameter int          LAT      = 4,
   parameter logic [31:0] BAD_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read_enable,
   input  logic [63:0] read_addr,
   input  logic [63:0] read_size,
   input  logic        finish_read,
   input  logic        write_enable,
   input  logic [63:0] write_addr,
   input  logic [31:0] write_data,
   input  logic        finish_write,
   output logic [63:0] read_ready,
   output logic [31:0] read_data,
   output logic [63:0] write_ready,
   output logic        addr_err,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);
   localparam int          AW   = $clog2(DEPTH);
   localparam int          CW   = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [63:0] SPAN = 64'(DEPTH) << 2;

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [63:0]     r_addr;
   logic [31:0]     r_wdata;
   logic [31:0]     r_rdata;
   logic            r_rd_rdy, r_wr_rdy, r_err;
   logic [31:0]     r_mem [0:DEPTH-1];

   logic            w_cap_rd, w_cap_wr, w_rd_done, w_wr_done;
   logic [63:0]     w_off;
   logic            w_in_range;
   logic [AW-1:0]   w_idx;
   logic            w_unused;

   // Stride and beat acknowledges carry no information for a one-word-per-access model.
   assign w_unused   = ^{read_size, finish_read, finish_write};

   // Offset test avoids computing BASE+SPAN, which could wrap at the top of the space.
   assign w_off      = r_addr - BASE;
   assign w_in_range = (r_addr >= BASE) && (w_off < SPAN);
   assign w_idx      = w_off[AW+1:2];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cap_rd    = 1'b0;
      w_cap_wr    = 1'b0;
      w_rd_done   = 1'b0;
      w_wr_done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (read_enable) begin
               w_cap_rd    = 1'b1;
               w_cnt_nxt   = CW'(LAT - 1);
               w_state_nxt = RD_WAIT;
            end else if (write_enable) begin
               w_cap_wr    = 1'b1;
               w_cnt_nxt   = CW'(LAT - 1);
               w_state_nxt = WR_WAIT;
            end
         end
         RD_WAIT: begin
            if (r_cnt == '0) begin
               w_rd_done   = 1'b1;
               w_state_nxt = RESP;
            end else begin
               w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         WR_WAIT: begin
            if (r_cnt == '0) begin
               w_wr_done   = 1'b1;
               w_state_nxt = RESP;
            end else begin
               w_cnt_nxt   = r_cnt - CW'(1);
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_rd_rdy <= 1'b0;
         r_wr_rdy <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rd_rdy <= w_rd_done;
         r_wr_rdy <= w_wr_done;
         if (w_cap_rd) r_addr <= read_addr;
         if (w_cap_wr) begin
            r_addr  <= write_addr;
            r_wdata <= write_data;
         end
         if (w_rd_done) r_rdata <= w_in_range ? r_mem[w_idx] : BAD_DATA;
         if ((w_rd_done || w_wr_done) && !w_in_range) r_err <= 1'b1;
      end
   end

   // Array deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_done && w_in_range) r_mem[w_idx] <= r_wdata;
   end

`ifdef MEM_RESP_STATS_EN
   logic [31:0] r_rd_cnt, r_wr_cnt;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_rd_done) r_rd_cnt <= r_rd_cnt + 32'd1;
         if (w_wr_done) r_wr_cnt <= r_wr_cnt + 32'd1;
      end
   end
   assign rd_count = r_rd_cnt;
   assign wr_count = r_wr_cnt;
`else
   assign rd_count = '0;
   assign wr_count = '0;
`endif

   assign read_ready  = {63'd0, r_rd_rdy};
   assign write_ready = {63'd0, r_wr_rdy};
   assign read_data   = r_rdata;
   assign addr_err    = r_err;
endmodule
